m_fetch_buf: RTL
================

// Module: m_fetch_buf
// PURPOSE
//  Instruction fetch stream buffer between the pipelined core's fetch port and a
//  multi-cycle instruction memory. Holds up to DEPTH consecutive words, prefetches
//  sequentially and drives the core's stall input until the word at w_pc is available.
// PARAMETERS
//  DEPTH  4  number of buffered words (power of 2, >=2)
// PORTS
//  w_clk    in   1   clock, all state updates on posedge
//  w_rst    in   1   reset, synchronous, active-high
//  w_pc     in   32  fetch address from core (word address = w_pc[31:2])
//  w_ir     out  32  instruction for w_pc; valid when w_stall=0
//  w_stall  out  1   1 = core must hold w_pc
//  w_flush  in   1   invalidate buffer (fence.i / redirect); 1-cycle pulse
//  w_mreq   out  1   memory request, held high until w_mack
//  w_maddr  out  32  request address, stable while w_mreq=1, [1:0]=0
//  w_mack   in   1   1-cycle ack; w_mdata valid same cycle
//  w_mdata  in   32  returned word
//  w_nhit   out  32  cycles with w_stall=0 (wraps)
//  w_nmiss  out  32  demand requests issued (wraps)
// BEHAVIOUR
//  State: r_base (word address of head), r_head, r_cnt (0..DEPTH), FSM r_st, counters.
//  Reset: r_cnt=0, r_head=0, r_base=0, r_st=IDLE, w_mreq=0, w_maddr=0, counters=0;
//   w_stall=1 and w_ir=0 after reset (buffer empty).
//  Hit (comb): idx=w_pc[31:2]-r_base (mod 2^30); hit = idx<r_cnt; w_ir=buf[r_head+idx].
//  Forward (comb): r_st=REQ & w_mack & w_maddr[31:2]==w_pc[31:2] & w_maddr==next-fill
//   addr -> w_stall=0, w_ir=w_mdata (zero added latency on a miss return).
//  w_stall = ~(hit | forward). Read latency for a hit: 0 cycles.
//  Consume: on hit with idx>0: r_head+=idx, r_cnt-=idx, r_base=w_pc[31:2].
//  FSM:
//   IDLE: miss -> r_base=w_pc[31:2], r_cnt=0, issue w_maddr=w_pc, w_nmiss++, ->REQ.
//         else r_cnt<DEPTH -> prefetch w_maddr={r_base+r_cnt,2'b00}, ->REQ.
//         else stay (full, no request).
//   REQ:  w_mack -> write w_mdata at tail (r_head+r_cnt), r_cnt++, ->IDLE.
//         miss with w_pc != w_maddr -> r_base=w_pc[31:2], r_cnt=0, ->DROP.
//   DROP: w_mack -> discard data, ->IDLE (demand issued from IDLE next cycle).
//  Requests are never withdrawn: w_mreq/w_maddr stay stable from issue until w_mack.
//  One idle cycle between consecutive requests (ack cycle -> IDLE -> next issue).
//  Simultaneous consume + fill: write at pre-consume tail; r_cnt = r_cnt-idx+1.
//  Full: r_cnt==DEPTH -> no prefetch; refill resumes once a consume frees an entry.
//  Address wrap: r_base+r_cnt wraps mod 2^30 (0xFFFFFFFC -> 0x00000000).
//  w_flush (highest priority): r_cnt=0; REQ->DROP; IDLE/DROP keep state; w_stall=1
//   that cycle regardless of hit; counters untouched.
//  w_rst mid-request: all state cleared, w_mreq=0; a late w_mack after reset is ignored.
//  w_pc[1:0] ignored.
// STRUCTURE
//  Shared package: FSM state encodings (IDLE/REQ/DROP), DEPTH default, word-address
//   width constant.
//  Sub-module m_fb_queue: DEPTH x 32 circular storage, 1 write port (tail), 1 comb
//   read port (head+idx), head/cnt pointers; control FSM stays in m_fetch_buf.
// TESTING
//  1 Reset then w_pc=0x00, memory 3-cycle ack -> w_stall=1 until ack cycle, w_ir=mem[0]
//    on ack cycle (forward), w_nmiss=1.
//  2 Straight-line pc 0x00,0x04,..,0x3C, 1-cycle mem -> after warm-up prefetches keep
//    r_cnt>0; no stall after first fill when mem faster than consume; w_ir matches.
//  3 Branch: buffer holds 0x10..0x1C, w_pc jumps to 0x100 while prefetch of 0x20 in
//    flight -> 0x20 data discarded (DROP), next request w_maddr=0x100, w_nmiss++.
//  4 Fill to DEPTH=4 with core stalled on same pc -> w_mreq stays 0 once r_cnt=4;
//    advance pc by 8 -> r_cnt=2, prefetch resumes at base+4 words.
//  5 w_flush on a hit cycle at 0x08 -> w_stall=1 that cycle, refetch from 0x08 follows.
//  6 w_pc=0xFFFFFFF8 sequential -> prefetch addresses 0xFFFFFFFC then 0x00000000;
//    w_rst asserted while w_mreq=1 -> w_mreq=0 next cycle, stray w_mack ignored.

Source files
------------

// File: rtl/m_fetch_buf_pkg.sv
// Shared definitions for the instruction fetch stream buffer.
package m_fetch_buf_pkg;

   localparam int unsigned FB_DEPTH = 4;   // default buffered word count
   localparam int unsigned WA_W     = 30;  // word-address width (byte address [31:2])

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fb_st_e;

endpackage

// File: rtl/m_fb_queue.sv
// Circular word store: one tail write port, one combinational read port at head+idx.
module m_fb_queue #(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PW    = $clog2(DEPTH),
   localparam int unsigned CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  logic [31:0]   push_data,
   input  logic [CW-1:0] pop,
   input  logic [PW-1:0] rd_idx,
   output logic [31:0]   rd_data,
   output logic [CW-1:0] cnt
);

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;

   assign tail    = head + cnt[PW-1:0];
   assign rd_data = mem[head + rd_idx];

   // Pointer update: push lands at the pre-pop tail, pop advances the head
   always_ff @(posedge clk) begin
      if (rst) begin
         head <= '0;
         cnt  <= '0;
      end else begin
         head <= head + pop[PW-1:0];
         cnt  <= clr ? '0 : cnt - pop + CW'(push);
      end
   end

   // Word storage, written at the tail on fill
   always_ff @(posedge clk) begin
      if (push) mem[tail] <= push_data;
   end

endmodule

// File: rtl/m_fetch_buf.sv
// Fetch stream buffer: serves the core from buffered words, prefetches sequentially
// from a multi-cycle instruction memory and stalls the core until w_pc is available.
module m_fetch_buf
   import m_fetch_buf_pkg::*;
#(
   parameter int unsigned DEPTH = FB_DEPTH
) (
   input  logic        w_clk,
   input  logic        w_rst,
   input  logic [31:0] w_pc,
   output logic [31:0] w_ir,
   output logic        w_stall,
   input  logic        w_flush,
   output logic        w_mreq,
   output logic [31:0] w_maddr,
   input  logic        w_mack,
   input  logic [31:0] w_mdata,
   output logic [31:0] w_nhit,
   output logic [31:0] w_nmiss
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   fb_st_e          r_st, st_n;
   logic [WA_W-1:0] r_base, base_n;
   logic [WA_W-1:0] wa_pc, idx, fill_wa;
   logic [CW-1:0]   q_cnt, pop, cnt_left;
   logic [31:0]     q_rd, maddr_n;
   logic            hit, fwd, q_clr, q_push, mreq_n, miss_inc;

   m_fb_queue #(.DEPTH(DEPTH)) u_queue (
      .clk       (w_clk),
      .rst       (w_rst),
      .clr       (q_clr),
      .push      (q_push),
      .push_data (w_mdata),
      .pop       (pop),
      .rd_idx    (idx[PW-1:0]),
      .rd_data   (q_rd),
      .cnt       (q_cnt)
   );

   // Hit lookup and miss-return forwarding
   always_comb begin
      wa_pc   = w_pc[31:2];
      idx     = wa_pc - r_base;
      fill_wa = r_base + WA_W'(q_cnt);
      hit     = idx < WA_W'(q_cnt);
      fwd     = (r_st == ST_REQ) && w_mack &&
                (w_maddr[31:2] == wa_pc) && (w_maddr[31:2] == fill_wa);
      w_stall = w_flush || !(hit || fwd);
      if (fwd)      w_ir = w_mdata;
      else if (hit) w_ir = q_rd;
      else          w_ir = '0;
   end

   // Request FSM next state, consume and fill control
   always_comb begin
      st_n     = r_st;
      base_n   = r_base;
      maddr_n  = w_maddr;
      mreq_n   = w_mreq;
      q_clr    = 1'b0;
      q_push   = 1'b0;
      pop      = '0;
      miss_inc = 1'b0;
      cnt_left = q_cnt;
      if (w_flush) begin
         q_clr = 1'b1;
         // An ack arriving with the flush retires the request here; waiting in
         // DROP for it would never end.
         if (r_st != ST_IDLE) begin
            if (w_mack) begin
               st_n   = ST_IDLE;
               mreq_n = 1'b0;
            end else begin
               st_n = ST_DROP;
            end
         end
      end else begin
         case (r_st)
            ST_IDLE: begin
               if (!hit) begin
                  base_n   = wa_pc;
                  q_clr    = 1'b1;
                  maddr_n  = {wa_pc, 2'b00};
                  mreq_n   = 1'b1;
                  miss_inc = 1'b1;
                  st_n     = ST_REQ;
               end else begin
                  if (idx != '0) begin
                     pop    = idx[CW-1:0];
                     base_n = wa_pc;
                  end
                  cnt_left = q_cnt - pop;
                  if (cnt_left < CW'(DEPTH)) begin
                     maddr_n = {fill_wa, 2'b00};
                     mreq_n  = 1'b1;
                     st_n    = ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (hit && idx != '0) begin
                  pop    = idx[CW-1:0];
                  base_n = wa_pc;
               end
               if (w_mack) begin
                  q_push = 1'b1;
                  mreq_n = 1'b0;
                  st_n   = ST_IDLE;
               end else if (!hit && (w_maddr[31:2] != wa_pc)) begin
                  base_n = wa_pc;
                  q_clr  = 1'b1;
                  st_n   = ST_DROP;
               end
            end
            ST_DROP: begin
               if (w_mack) begin
                  mreq_n = 1'b0;
                  st_n   = ST_IDLE;
               end
            end
            default: st_n = ST_IDLE;
         endcase
      end
   end

   // State, request and counter registers
   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_st    <= ST_IDLE;
         r_base  <= '0;
         w_mreq  <= 1'b0;
         w_maddr <= '0;
         w_nhit  <= '0;
         w_nmiss <= '0;
      end else begin
         r_st    <= st_n;
         r_base  <= base_n;
         w_mreq  <= mreq_n;
         w_maddr <= maddr_n;
         if (!w_stall) w_nhit  <= w_nhit + 32'd1;
         if (miss_inc) w_nmiss <= w_nmiss + 32'd1;
      end
   end

endmodule
